// File: rtl/synthetic_2_flow_sequencer.sv
// synthetic_2_flow_sequencer: timed actuator sequencer for the Planar_Synthetic_2 fluidic chip
module synthetic_2_flow_sequencer #(
  parameter int CNT_W         = 16,
  parameter int FILL_CYC      = 1000,
  parameter int MIX_CYC       = 4000,
  parameter int HEAT_CYC      = 8000,
  parameter int DRAIN_TIMEOUT = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       out_detect,
  output logic       inlet_valve,
  output logic [3:0] mixer_en,
  output logic [3:0] heater_en,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] stage
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FILL = 4'd1, MIX1 = 4'd2, MIX2 = 4'd3, HEAT13 = 4'd4, MIX3 = 4'd5,
    HEAT2 = 4'd6, MIX4 = 4'd7, HEAT4 = 4'd8, DRAIN = 4'd9, DONE = 4'd10, ERROR = 4'd15
  } state_t;
  // A zero dwell behaves as a one-cycle dwell
  localparam logic [CNT_W-1:0] FILL_L  = CNT_W'(FILL_CYC > 0 ? FILL_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] MIX_L   = CNT_W'(MIX_CYC > 0 ? MIX_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] HEAT_L  = CNT_W'(HEAT_CYC > 0 ? HEAT_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] DRAIN_L = CNT_W'(DRAIN_TIMEOUT > 0 ? DRAIN_TIMEOUT - 1 : 0);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, load;
  logic expired;
  assign expired = cnt == '0;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = start ? FILL : IDLE;
      FILL:    nxt = expired ? MIX1 : FILL;
      MIX1:    nxt = expired ? MIX2 : MIX1;
      MIX2:    nxt = expired ? HEAT13 : MIX2;
      HEAT13:  nxt = expired ? MIX3 : HEAT13;
      MIX3:    nxt = expired ? HEAT2 : MIX3;
      HEAT2:   nxt = expired ? MIX4 : HEAT2;
      MIX4:    nxt = expired ? HEAT4 : MIX4;
      HEAT4:   nxt = expired ? DRAIN : HEAT4;
      DRAIN:   nxt = out_detect ? DONE : expired ? ERROR : DRAIN;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  assign load = (nxt == FILL) ? FILL_L :
                (nxt inside {MIX1, MIX2, MIX3, MIX4}) ? MIX_L :
                (nxt inside {HEAT13, HEAT2, HEAT4}) ? HEAT_L :
                (nxt == DRAIN) ? DRAIN_L : '0;
  // Outputs decode the next state so actuators switch on the same edge as the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      inlet_valve <= 1'b0;
      mixer_en    <= '0;
      heater_en   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      stage       <= '0;
    end else begin
      state       <= nxt;
      cnt         <= (nxt != state) ? load : expired ? cnt : cnt - 1'b1;
      inlet_valve <= nxt == FILL || nxt == DRAIN;
      mixer_en    <= {nxt == MIX4, nxt == MIX3, nxt == MIX2, nxt == MIX1};
      heater_en   <= {nxt == HEAT4, nxt == HEAT13, nxt == HEAT2, nxt == HEAT13};
      busy        <= nxt != IDLE;
      done        <= nxt == DONE;
      error       <= (state == IDLE && nxt == FILL) ? 1'b0 : (nxt == ERROR) | error;
      stage       <= nxt;
    end
  end
endmodule
